ddr_line_fetch: RTL

- Upstream feeder of the HDMI read buffer.
- Issues AXI4 read bursts to DDR, one video line at a time, on request from the display side.
- Streams returned 256-bit beats out as buf_wr_en/buf_wr_data.
- Selects the source frame bank from frame_instruct, so the display alternates between two DDR frame buffers.

---
 rtl/ddr_line_fetch_pkg.sv | 29 ++
 rtl/ddr_line_fetch_cdc.sv | 30 +++
 rtl/ddr_line_fetch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_line_fetch_pkg.sv
// Shared definitions for the DDR line fetcher: FSM encoding, line geometry
// helpers and the default frame bank bases.
package ddr_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LINE = 3'd1,
    S_ADDR      = 3'd2,
    S_DATA      = 3'd3,
    S_DRAIN     = 3'd4
  } fetch_state_t;

  localparam logic [27:0] BANK0_BASE_DEF = 28'h000_0000;
  localparam logic [27:0] BANK1_BASE_DEF = 28'h020_0000;

  function automatic int beats_per_line(input int h_width, input int dq_width);
    return (h_width * 2) / dq_width;
  endfunction

  function automatic int bursts_per_line(input int h_width, input int dq_width,
                                         input int burst_len);
    return beats_per_line(h_width, dq_width) / burst_len;
  endfunction

  function automatic int line_bytes(input int h_width);
    return h_width * 2;
  endfunction

endpackage

// File: rtl/ddr_line_fetch_cdc.sv
// Two-flop synchroniser with a one-cycle edge pulse: any edge in toggle
// mode, rising edge only otherwise.
module cdc_toggle_sync #(
  parameter bit TOGGLE_MODE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = TOGGLE_MODE ? (r_sync ^ r_prev) : (r_sync & ~r_prev);

endmodule

// File: rtl/ddr_line_fetch.sv
// Fetches one video line per display request as AXI4 read bursts and streams
// the beats to the line buffer. Define DDR_LINE_PREFETCH_EN to free-run ahead.
module ddr_line_fetch
  import ddr_fetch_pkg::*;
#(
  parameter int DQ_WIDTH   = 32,
  parameter int H_WIDTH    = 1280,
  parameter int H_HEIGHT   = 720,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BANK0_BASE = ADDR_WIDTH'(BANK0_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(BANK1_BASE_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_fsync,
  input  logic                    line_req_tog,
  input  logic                    frame_instruct,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DQ_WIDTH*8-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    buf_wr_en,
  output logic [DQ_WIDTH*8-1:0]   buf_wr_data,
  output logic                    line_ovf,
  output logic [2:0]              o_dbg_state
);

  localparam int BPL     = bursts_per_line(H_WIDTH, DQ_WIDTH, BURST_LEN);
  localparam int LINE_W  = $clog2(H_HEIGHT + 1);
  localparam int BURST_W = (BPL > 1) ? $clog2(BPL) : 1;
  localparam logic [LINE_W-1:0]     H_MAX       = LINE_W'(H_HEIGHT);
  localparam logic [BURST_W-1:0]    BURST_LAST  = BURST_W'(BPL - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(line_bytes(H_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] BURST_STRIDE = ADDR_WIDTH'(BURST_LEN * DQ_WIDTH);

`ifdef DDR_LINE_PREFETCH_EN
  localparam logic PREFETCH = 1'b1;
`else
  localparam logic PREFETCH = 1'b0;
`endif

  if ((H_WIDTH * 2) % (DQ_WIDTH * BURST_LEN) != 0) begin : g_bad_geometry
    $error("ddr_line_fetch: a line must be a whole number of bursts");
  end

  logic w_fstart;
  logic w_line_req;
  logic w_req;
  logic w_last;

  cdc_toggle_sync #(.TOGGLE_MODE(1'b0)) u_fsync_sync (
    .clk(clk), .rst(rst), .i_async(rd_fsync), .o_pulse(w_fstart)
  );

  cdc_toggle_sync #(.TOGGLE_MODE(1'b1)) u_req_sync (
    .clk(clk), .rst(rst), .i_async(line_req_tog), .o_pulse(w_line_req)
  );

  assign w_req  = PREFETCH ? 1'b0 : w_line_req;
  assign w_last = axi_rvalid && axi_rlast;

  fetch_state_t            r_state, nxt_state;
  logic [ADDR_WIDTH-1:0]   r_base, nxt_base;
  logic [LINE_W-1:0]       r_line, nxt_line;
  logic [BURST_W-1:0]      r_burst, nxt_burst;
  logic                    r_pending, nxt_pending;
  logic                    r_ovf, nxt_ovf;
  logic                    r_abort, nxt_abort;
  logic                    nxt_wr_en;
  logic [DQ_WIDTH*8-1:0]   nxt_wr_data;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    r_arvalid;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic                    r_wr_en;
  logic [DQ_WIDTH*8-1:0]   r_wr_data;

  // A frame start always wins over a same-cycle request; r_abort remembers
  // that an address already on the bus must still complete, then be drained.
  always_comb begin
    nxt_state   = r_state;
    nxt_base    = r_base;
    nxt_line    = r_line;
    nxt_burst   = r_burst;
    nxt_pending = r_pending;
    nxt_ovf     = r_ovf;
    nxt_abort   = r_abort;
    nxt_wr_en   = 1'b0;
    nxt_wr_data = r_wr_data;
    if (w_fstart) begin
      nxt_base    = frame_instruct ? BANK1_BASE : BANK0_BASE;
      nxt_line    = '0;
      nxt_burst   = '0;
      nxt_pending = PREFETCH;
      nxt_ovf     = 1'b0;
      case (r_state)
        S_ADDR: begin
          if (axi_arready) begin
            nxt_state = S_DRAIN;
            nxt_abort = 1'b0;
          end else begin
            nxt_abort = 1'b1;
          end
        end
        S_DATA, S_DRAIN: nxt_state = w_last ? S_WAIT_LINE : S_DRAIN;
        default:         nxt_state = S_WAIT_LINE;
      endcase
    end else begin
      if (w_req && (r_state == S_ADDR || r_state == S_DATA || r_state == S_DRAIN)) begin
        if (r_pending) nxt_ovf = 1'b1;
        else           nxt_pending = 1'b1;
      end
      case (r_state)
        S_WAIT_LINE: begin
          if (r_pending || w_req) begin
            if (r_line < H_MAX) begin
              nxt_state   = S_ADDR;
              nxt_pending = r_pending && w_req;
            end else begin
              nxt_pending = 1'b0;
            end
          end
        end
        S_ADDR: begin
          if (axi_arready) begin
            nxt_state = r_abort ? S_DRAIN : S_DATA;
            nxt_abort = 1'b0;
          end
        end
        S_DATA: begin
          if (axi_rvalid) begin
            nxt_wr_en   = 1'b1;
            nxt_wr_data = axi_rdata;
            if (axi_rlast) begin
              if (r_burst == BURST_LAST) begin
                nxt_burst = '0;
                nxt_line  = r_line + 1'b1;
                nxt_state = S_WAIT_LINE;
                if (PREFETCH && (nxt_line < H_MAX)) nxt_pending = 1'b1;
              end else begin
                nxt_burst = r_burst + 1'b1;
                nxt_state = S_ADDR;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_last) nxt_state = S_WAIT_LINE;
        end
        default: ;
      endcase
    end
  end

  assign w_addr = nxt_base + ADDR_WIDTH'(nxt_line) * LINE_STRIDE
                           + ADDR_WIDTH'(nxt_burst) * BURST_STRIDE;

  // AXI AR: arvalid/araddr are loaded on entry to ADDR and held unchanged
  // until the cycle arvalid && arready, which is the single handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_line    <= '0;
      r_burst   <= '0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
      r_abort   <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state   <= nxt_state;
      r_base    <= nxt_base;
      r_line    <= nxt_line;
      r_burst   <= nxt_burst;
      r_pending <= nxt_pending;
      r_ovf     <= nxt_ovf;
      r_abort   <= nxt_abort;
      r_arvalid <= (nxt_state == S_ADDR);
      if (nxt_state == S_ADDR && r_state != S_ADDR) r_araddr <= w_addr;
      r_wr_en   <= nxt_wr_en;
      r_wr_data <= nxt_wr_data;
    end
  end

  assign axi_arlen   = 8'(BURST_LEN - 1);
  assign axi_arvalid = r_arvalid;
  assign axi_araddr  = r_araddr;
  assign buf_wr_en   = r_wr_en;
  assign buf_wr_data = r_wr_data;
  assign line_ovf    = r_ovf;
  assign o_dbg_state = r_state;

endmodule
